// File: rtl/image_downscaler.sv
// image_downscaler: streaming box-filter downscaler, each output is the rounded mean
// of one non-overlapping SX x SY input block, emitted in output raster order.
module image_downscaler #(
   parameter int pixel_width_p   = 16,
   parameter int input_width_p   = 640,
   parameter int input_height_p  = 480,
   parameter int output_width_p  = 80,
   parameter int output_height_p = 60
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic [pixel_width_p-1:0] pixel_i,
   input  logic                     valid_i,
   output logic                     ready_o,
   output logic [pixel_width_p-1:0] pixel_o,
   output logic                     valid_o,
   input  logic                     ready_i
);
   localparam int SX  = input_width_p / output_width_p;
   localparam int SY  = input_height_p / output_height_p;
   localparam int N   = SX * SY;
   localparam int LSX = $clog2(SX);
   localparam int LN  = LSX + $clog2(SY);
   localparam int XW  = input_width_p > 1 ? $clog2(input_width_p) : 1;
   localparam int YW  = input_height_p > 1 ? $clog2(input_height_p) : 1;
   localparam int OXW = output_width_p > 1 ? $clog2(output_width_p) : 1;
   localparam int HW  = pixel_width_p + LSX;
   localparam int AW  = pixel_width_p + LN;

   logic [XW-1:0]            r_in_x;
   logic [YW-1:0]            r_in_y;
   logic [HW-1:0]            r_h_sum;
   logic [AW-1:0]            r_col_acc [output_width_p];
   logic [pixel_width_p-1:0] r_pixel;
   logic                     r_valid;
   logic                     w_accept, w_emit, w_col_wr;
   logic                     w_bx_first, w_bx_last, w_by_first, w_by_last, w_x_last, w_y_last;
   logic [OXW-1:0]           w_out_x;
   logic [HW-1:0]            w_row_sum;
   logic [AW-1:0]            w_total;
   logic [pixel_width_p-1:0] w_rounded;

   always_comb begin
      ready_o    = ~r_valid | ready_i;
      pixel_o    = r_pixel;
      valid_o    = r_valid;
      w_accept   = valid_i & ready_o;
      w_bx_first = (r_in_x % XW'(SX)) == '0;
      w_bx_last  = (r_in_x % XW'(SX)) == XW'(SX - 1);
      w_by_first = (r_in_y % YW'(SY)) == '0;
      w_by_last  = (r_in_y % YW'(SY)) == YW'(SY - 1);
      w_x_last   = r_in_x == XW'(input_width_p - 1);
      w_y_last   = r_in_y == YW'(input_height_p - 1);
      w_out_x    = OXW'(r_in_x / XW'(SX));
      w_row_sum  = (w_bx_first ? '0 : r_h_sum) + HW'(pixel_i);
      w_total    = (SY == 1 ? '0 : r_col_acc[w_out_x]) + AW'(w_row_sum);
      // round half up: bias by N/2 before dropping the log2(N) fraction bits
      w_rounded  = pixel_width_p'((w_total + AW'(N / 2)) >> LN);
      w_emit     = w_accept & w_bx_last & w_by_last;
      w_col_wr   = w_accept & w_bx_last & ~w_by_last;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_in_x  <= '0;
         r_in_y  <= '0;
         r_h_sum <= '0;
         r_pixel <= '0;
         r_valid <= 1'b0;
      end else begin
         if (w_accept) begin
            r_h_sum <= w_row_sum;
            r_in_x  <= w_x_last ? '0 : r_in_x + 1'b1;
            if (w_x_last) r_in_y <= w_y_last ? '0 : r_in_y + 1'b1;
         end
         if (w_emit) begin
            r_pixel <= w_rounded;
            r_valid <= 1'b1;
         end else if (ready_i) begin
            r_valid <= 1'b0;
         end
      end
   end

   // the first row of each block band overwrites, so the array never needs clearing
   always_ff @(posedge clk_i) begin
      if (!reset_i && w_col_wr)
         r_col_acc[w_out_x] <= w_by_first ? AW'(w_row_sum) : r_col_acc[w_out_x] + AW'(w_row_sum);
   end
endmodule

// File: tb/tb_image_downscaler.sv
// tb_image_downscaler: directed checks of a 32x16 -> 4x2 downscaler (8x8 blocks).
module tb_image_downscaler;
   logic        clk = 1'b0;
   logic        reset, valid_i, ready_i, ready_o, valid_o;
   logic [15:0] pixel_i, pixel_o;
   int          vectors = 0;
   int          miscompares = 0;
   logic [15:0] q[$];

   always #5 clk = ~clk;

   image_downscaler #(
      .pixel_width_p(16), .input_width_p(32), .input_height_p(16),
      .output_width_p(4), .output_height_p(2)
   ) dut (
      .clk_i(clk), .reset_i(reset), .pixel_i(pixel_i), .valid_i(valid_i),
      .ready_o(ready_o), .pixel_o(pixel_o), .valid_o(valid_o), .ready_i(ready_i)
   );

   always @(negedge clk) if (!reset && valid_o && ready_i) q.push_back(pixel_o);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] pix(input int mode, input int x, input int y);
      case (mode)
         0: return 16'h1234;
         1: return 16'(x);
         2: return 16'hFFFF;
         3: return (x < 8 && y < 8) ? 16'(y * 8 + x) : 16'h0;
         default: return 16'(y);
      endcase
   endfunction

   function automatic logic [15:0] expv(input int mode, input int ox, input int oy);
      case (mode)
         0: return 16'h1234;
         1: return 16'(8 * ox + 4);
         2: return 16'hFFFF;
         3: return (ox == 0 && oy == 0) ? 16'd32 : 16'd0;
         default: return 16'(8 * oy + 4);
      endcase
   endfunction

   task automatic send(input logic [15:0] p, input bit rnd);
      int  n = 0;
      logic r;
      if (rnd) while ($urandom_range(0, 2) == 0) begin
         valid_i = 1'b0;
         ready_i = 1'($urandom_range(0, 1));
         tick();
      end
      valid_i = 1'b1;
      pixel_i = p;
      forever begin
         @(negedge clk);
         r = ready_o;
         tick();
         if (r) break;
         if (rnd) ready_i = 1'($urandom_range(0, 1));
         n++;
         if (n > 1000) begin
            $display("FAIL send_timeout: observed no accept expected accept within 1000 cycles");
            $fatal(1);
         end
      end
      valid_i = 1'b0;
      if (rnd) ready_i = 1'($urandom_range(0, 1));
   endtask

   task automatic send_frame(input int mode, input bit rnd);
      for (int y = 0; y < 16; y++)
         for (int x = 0; x < 32; x++) send(pix(mode, x, y), rnd);
   endtask

   task automatic drain;
      valid_i = 1'b0;
      ready_i = 1'b1;
      repeat (3) tick();
      chk("drain_valid", 32'(valid_o), 32'd0);
   endtask

   task automatic check_frame(input string tag, input int mode);
      chk({tag, "_count"}, q.size(), 32'd8);
      for (int i = 0; i < 8 && i < q.size(); i++)
         chk($sformatf("%s_px%0d", tag, i), 32'(q[i]), 32'(expv(mode, i % 4, i / 4)));
      q.delete();
   endtask

   initial begin
      int bad;
      reset = 1'b1; valid_i = 1'b0; ready_i = 1'b0; pixel_i = '0;
      repeat (2) tick();
      reset = 1'b0;
      chk("rst_valid", 32'(valid_o), 32'd0);
      chk("rst_pixel", 32'(pixel_o), 32'd0);
      chk("rst_ready", 32'(ready_o), 32'd1);

      ready_i = 1'b1;
      send_frame(0, 1'b0); drain(); check_frame("const", 0);
      send_frame(1, 1'b0); drain(); check_frame("ramp", 1);
      send_frame(2, 1'b0); drain(); check_frame("sat", 2);

      for (int i = 0; i < 512; i++) begin
         send(pix(3, i % 32, i / 32), 1'b0);
         if (i == 230) chk("lat_before", 32'(valid_o), 32'd0);
         if (i == 231) chk("lat_after", 32'(valid_o), 32'd1);
         if (i == 231) chk("lat_pixel", 32'(pixel_o), 32'd32);
      end
      drain(); check_frame("block", 3);
      send_frame(4, 1'b0); drain(); check_frame("yramp", 4);

      ready_i = 1'b0;
      for (int i = 0; i < 232; i++) send(16'h1234, 1'b0);
      chk("bp_valid", 32'(valid_o), 32'd1);
      chk("bp_ready", 32'(ready_o), 32'd0);
      bad = 0;
      repeat (50) begin
         @(negedge clk);
         if (valid_o !== 1'b1 || pixel_o !== 16'h1234 || ready_o !== 1'b0) bad++;
      end
      tick();
      chk("bp_stable", 32'(bad), 32'd0);
      ready_i = 1'b1;
      for (int i = 232; i < 512; i++) send(16'h1234, 1'b0);
      drain(); check_frame("bp", 0);

      send_frame(1, 1'b1); drain(); check_frame("rand", 1);

      ready_i = 1'b0;
      for (int i = 0; i < 232; i++) send(16'h0500, 1'b0);
      chk("mid_valid", 32'(valid_o), 32'd1);
      reset = 1'b1; valid_i = 1'b1; ready_i = 1'b1; pixel_i = 16'hABCD;
      tick();
      reset = 1'b0; valid_i = 1'b0;
      chk("mid_rst_valid", 32'(valid_o), 32'd0);
      chk("mid_rst_pixel", 32'(pixel_o), 32'd0);
      chk("mid_rst_ready", 32'(ready_o), 32'd1);
      send_frame(1, 1'b0); drain(); check_frame("mid_ramp", 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/image_downscaler.md
# image_downscaler

Streaming box-filter downscaler: accepts a raster-order frame of `input_width_p` x `input_height_p` pixels over a valid/ready interface. It emits the `output_width_p` x `output_height_p` frame in which each output pixel is the rounded mean of its non-overlapping input block. It is the reverse-direction counterpart of `image_scaler`: it shares the same pixel width and handshake, and maps 640x480 down to 80x60 for preview, statistics and loop-back checks of the scaler.

## Interface
- `pixel_width_p`, 16, bits per pixel (unsigned).
- `input_width_p`, 640, input pixels per line.
- `input_height_p`, 480, input lines per frame.
- `output_width_p`, 80, output pixels per line. `SX = input_width_p/output_width_p` must be an integer power of two, at least 1.
- `output_height_p`, 60, output lines per frame. `SY = input_height_p/output_height_p` must be an integer power of two, at least 1.
- `clk_i`, in, 1, single clock; all state updates on its rising edge.
- `reset_i`, in, 1, synchronous active-high reset.
- `pixel_i`, in, `pixel_width_p`, input pixel.
- `valid_i`, in, 1, `pixel_i` is valid.
- `ready_o`, out, 1, block accepts `pixel_i` this cycle.
- `pixel_o`, out, `pixel_width_p`, output pixel.
- `valid_o`, out, 1, `pixel_o` is valid.
- `ready_i`, in, 1, downstream accepts `pixel_o` this cycle.

## Operation
- **Input accept:** an input pixel is accepted when `valid_i & ready_o`. An output pixel is accepted when `valid_o & ready_i`.
- **Counters:**
  - `in_x` runs 0..`input_width_p`-1. `in_y` runs 0..`input_height_p`-1.
  - Both advance only on input accept, in raster order.
  - After (`input_width_p`-1, `input_height_p`-1) both wrap to 0; the next frame starts with no gap.
- **Block indices:** `bx = in_x % SX`, `by = in_y % SY`, `out_x = in_x / SX`.
- **Widths:**
  - Let `N = SX*SY`.
  - Horizontal sum register `h_sum` is `pixel_width_p + log2(SX)` bits.
  - Column accumulator RAM/array `col_acc[0..output_width_p-1]` is `pixel_width_p + log2(N)` bits per entry.
  - No sum can overflow.
- **Horizontal stage, per accepted pixel:**
  - If `bx==0`: `h_sum <= pixel_i`.
  - Else: `h_sum <= h_sum + pixel_i`.
  - `row_sum = (bx==0 ? 0 : h_sum) + pixel_i` (combinational). It is complete when `bx==SX-1`.
- **Vertical stage, on accept with `bx==SX-1`:**
  - If `by==0`: `col_acc[out_x] <= row_sum`. This overwrites the entry, so no clear is ever required.
  - Else if `by<SY-1`: `col_acc[out_x] <= col_acc[out_x] + row_sum`.
  - If `by==SY-1`: `total = (SY==1 ? 0 : col_acc[out_x]) + row_sum`. Then load the output register with `pixel_o <= (total + N/2) >> log2(N)`, i.e. round half up, and set `valid_o <= 1`. The result never exceeds 2^`pixel_width_p`-1.
- **Output register:**
  - Single entry.
  - `valid_o` clears on output accept, unless it is reloaded in the same cycle.
  - A simultaneous output accept and reload yields the new pixel with `valid_o` remaining 1.
- **Flow control:**
  - `ready_o = ~valid_o | ready_i`.
  - This is a combinational path from `ready_i`. `ready_o` does not depend on `valid_i`.
  - `pixel_o` and `valid_o` hold stable while `valid_o & ~ready_i`.
- **Output order:** output pixels emerge in output raster order, exactly `output_width_p*output_height_p` per input frame.

## Timing
- **Reset** (`reset_i` high at a rising edge):
  - `valid_o=0`, `pixel_o=0`, `in_x=in_y=0`, `h_sum=0`.
  - `ready_o` therefore reads 1 in the cycle after reset.
  - `col_acc` is not reset.
  - Reset mid-frame discards the partial frame; the next accepted pixel is treated as (0,0).
  - `reset_i` has priority over any handshake in the same cycle.
- **Latency:** `valid_o` rises the cycle after the accept of the input pixel with `bx==SX-1` and `by==SY-1`.
- **Throughput:**
  - Input accepts one pixel per cycle while downstream is ready.
  - Input stalls only when `valid_o & ~ready_i`.
  - The stall applies to every input pixel, even those that would not produce output; this is the accepted simplification.
- **Idle:** `valid_i` low leaves all state unchanged.
- **Degenerate ratio:** with `SX=SY=1` the block is a one-stage registered pass-through.

## Test plan
- **Constant frame:** 640x480 frame of all 0x1234, `ready_i`=1 throughout -> exactly 4800 outputs, all 0x1234, then `valid_o`=0.
- **Horizontal ramp:** `pixel_i = in_x` -> every output line reads 4,12,20,…,636. Each value is 8*`out_x`+4, since a block mean of 8x+3.5 rounds up.
- **Saturation:** full frame of 0xFFFF -> all 4800 outputs 0xFFFF. There is no wrap, and no output reads 0x0000 or 0x7FFF.
- **Block rounding:**
  - Block (0,0) holds values 0..63 in raster order; all other pixels are 0.
  - Output (0,0) = 32 (round of 31.5).
  - Output (1,0) = 0.
- **Backpressure:**
  - Hold `ready_i`=0 when the first output appears -> `ready_o`=0 next cycle, `pixel_o`/`valid_o` stable for 50 cycles.
  - Release `ready_i` -> the stream resumes with 4800 total outputs matching the constant-frame result.
  - Random `ready_i`/`valid_i` toggling gives identical data.
- **Reset mid-frame:** accept 1000 pixels, assert `reset_i` for 1 cycle, then send a full ramp frame -> exactly 4800 outputs equal to the ramp expectation, with none from the partial frame.
